// File: rtl/hybrid_bht.sv
// hybrid_bht: branch history table combining gshare-indexed direction counters,
// a per-entry loop (run-length) predictor and a per-entry chooser counter.
// INSTR_PER_FETCH combinational predictions per cycle and one resolved update per cycle.
module hybrid_bht #(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned VLEN            = 39,
    parameter bit          RVC             = 1'b1,
    parameter int unsigned CTR_BITS        = 2,
    parameter int unsigned LOOP_BITS       = 4,
    parameter int unsigned GHR_BITS        = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       update_valid_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
    output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
    output logic [INSTR_PER_FETCH-1:0] pred_src_o,
    output logic [GHR_BITS-1:0]        ghr_o
);

    localparam int unsigned OFFSET       = RVC ? 1 : 2;
    localparam int unsigned NR_ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_IDX_BITS = $clog2(NR_ROWS);
    localparam int unsigned CB           = $clog2(INSTR_PER_FETCH);
    localparam int unsigned COL_W        = (CB > 0) ? CB : 1;

    typedef struct packed {
        logic                 valid;
        logic [CTR_BITS-1:0]  ctr;
        logic [CTR_BITS-1:0]  chs;
        logic                 last_taken;
        logic [LOOP_BITS-1:0] seq;
        logic [LOOP_BITS-1:0] run_t;
        logic [LOOP_BITS-1:0] run_nt;
    } entry_t;

    // Weakly taken direction counter, weakly prefer-counter chooser.
    localparam logic [CTR_BITS-1:0] CTR_RST = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CHS_RST = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam entry_t ENTRY_RST = '{valid: 1'b0, ctr: CTR_RST, chs: CHS_RST,
                                     last_taken: 1'b0, seq: '0, run_t: '0, run_nt: '0};

    entry_t                  tbl_q [NR_ROWS][INSTR_PER_FETCH];
    logic [GHR_BITS-1:0]     ghr_q;
    logic [GHR_BITS-1:0]     ghr_d;
    logic [ROW_IDX_BITS-1:0] ghr_ext;

    function automatic logic [ROW_IDX_BITS-1:0] row_of(input logic [VLEN-1:0] pc);
        return pc[CB+OFFSET +: ROW_IDX_BITS];
    endfunction

    function automatic logic [COL_W-1:0] col_of(input logic [VLEN-1:0] pc);
        if (CB == 0) return '0;
        return pc[OFFSET +: COL_W];
    endfunction

    function automatic logic loop_ok_f(input logic last, input logic [LOOP_BITS-1:0] seq,
                                       input logic [LOOP_BITS-1:0] run_t,
                                       input logic [LOOP_BITS-1:0] run_nt);
        logic [LOOP_BITS-1:0] run;
        run = last ? run_t : run_nt;
        return (run != '0) && (seq != '1);
    endfunction

    function automatic logic loop_pred_f(input logic last, input logic [LOOP_BITS-1:0] seq,
                                         input logic [LOOP_BITS-1:0] run_t,
                                         input logic [LOOP_BITS-1:0] run_nt);
        logic [LOOP_BITS-1:0] run;
        run = last ? run_t : run_nt;
        return (seq == run) ? !last : last;
    endfunction

    assign ghr_ext = ROW_IDX_BITS'(ghr_q);
    assign ghr_o   = ghr_q;

    // Only the index bits of the PCs are meaningful; the rest are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i, update_pc_i};

    // ---------------- prediction (combinational, registered state only) ----------------
    logic [ROW_IDX_BITS-1:0] pred_row;
    assign pred_row = row_of(vpc_i);

    // Per-slot selection between the loop predictor and the gshare counter.
    for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_pred
        logic lok, lp, cp, use_loop;
        assign lok = loop_ok_f(tbl_q[pred_row][g].last_taken, tbl_q[pred_row][g].seq,
                               tbl_q[pred_row][g].run_t, tbl_q[pred_row][g].run_nt);
        assign lp  = loop_pred_f(tbl_q[pred_row][g].last_taken, tbl_q[pred_row][g].seq,
                                 tbl_q[pred_row][g].run_t, tbl_q[pred_row][g].run_nt);
        assign cp  = tbl_q[pred_row ^ ghr_ext][g].ctr[CTR_BITS-1];
        assign use_loop = lok && (lp != cp) && tbl_q[pred_row][g].chs[CTR_BITS-1];
        assign pred_valid_o[g] = tbl_q[pred_row][g].valid;
        assign pred_taken_o[g] = use_loop ? lp : cp;
        assign pred_src_o[g]   = use_loop;
    end

    // ---------------- update ----------------
    logic                    upd_en;
    logic [ROW_IDX_BITS-1:0] upd_row, upd_crow;
    logic [COL_W-1:0]        upd_col;
    logic [CTR_BITS-1:0]     u_ctr, u_chs, ctr_d, chs_d;
    logic                    u_last, u_lok, u_lp;
    logic [LOOP_BITS-1:0]    u_seq, u_run_t, u_run_nt, seq_d, run_t_d, run_nt_d;

    assign upd_en   = update_valid_i && !debug_mode_i && !flush_i;
    assign upd_row  = row_of(update_pc_i);
    assign upd_crow = upd_row ^ ghr_ext;
    assign upd_col  = col_of(update_pc_i);
    assign u_ctr    = tbl_q[upd_crow][upd_col].ctr;
    assign u_chs    = tbl_q[upd_row][upd_col].chs;
    assign u_last   = tbl_q[upd_row][upd_col].last_taken;
    assign u_seq    = tbl_q[upd_row][upd_col].seq;
    assign u_run_t  = tbl_q[upd_row][upd_col].run_t;
    assign u_run_nt = tbl_q[upd_row][upd_col].run_nt;
    assign u_lok    = loop_ok_f(u_last, u_seq, u_run_t, u_run_nt);
    assign u_lp     = loop_pred_f(u_last, u_seq, u_run_t, u_run_nt);

    // Next values of the addressed entry fields, all derived from pre-edge state.
    always_comb begin
        ctr_d = u_ctr;
        if (update_taken_i && (u_ctr != '1)) begin
            ctr_d = u_ctr + CTR_BITS'(1);
        end else if (!update_taken_i && (u_ctr != '0)) begin
            ctr_d = u_ctr - CTR_BITS'(1);
        end

        seq_d    = u_seq;
        run_t_d  = u_run_t;
        run_nt_d = u_run_nt;
        if (update_taken_i == u_last) begin
            if (u_seq != '1) seq_d = u_seq + LOOP_BITS'(1);
        end else begin
            if (u_last) run_t_d = u_seq;
            else        run_nt_d = u_seq;
            seq_d = LOOP_BITS'(1);
        end

        chs_d = u_chs;
        if (u_lok && (u_lp != u_ctr[CTR_BITS-1])) begin
            if (u_lp == update_taken_i) begin
                if (u_chs != '1) chs_d = u_chs + CTR_BITS'(1);
            end else begin
                if (u_chs != '0) chs_d = u_chs - CTR_BITS'(1);
            end
        end

        ghr_d = GHR_BITS'({ghr_q, update_taken_i});
    end

    // Table and history state: async reset, sync flush (drops a coincident update), update write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NR_ROWS; r++) begin
                for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
                    tbl_q[r][c] <= ENTRY_RST;
                end
            end
            ghr_q <= '0;
        end else if (flush_i) begin
            for (int unsigned r = 0; r < NR_ROWS; r++) begin
                for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
                    tbl_q[r][c] <= ENTRY_RST;
                end
            end
            ghr_q <= '0;
        end else if (upd_en) begin
            // Counter lives at the history-hashed row; loop/chooser/valid at the plain row.
            tbl_q[upd_crow][upd_col].ctr       <= ctr_d;
            tbl_q[upd_row][upd_col].valid      <= 1'b1;
            tbl_q[upd_row][upd_col].chs        <= chs_d;
            tbl_q[upd_row][upd_col].last_taken <= update_taken_i;
            tbl_q[upd_row][upd_col].seq        <= seq_d;
            tbl_q[upd_row][upd_col].run_t      <= run_t_d;
            tbl_q[upd_row][upd_col].run_nt     <= run_nt_d;
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: tb/tb_hybrid_bht.sv
// Directed bench for hybrid_bht: default instance (GHR_BITS=8) plus a GHR_BITS=1
// instance for the loop-predictor pattern. Expected outputs are queued when the
// stimulus is driven and compared at the following falling clock edge.
module tb_hybrid_bht;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        flush     = 1'b0;
    logic        debug     = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_taken = 1'b0;
    logic [38:0] vpc       = '0;
    logic [38:0] upd_pc    = '0;

    logic [1:0] pv, pt, ps;
    logic [7:0] ghr;
    logic [1:0] pv1, pt1, ps1;
    logic [0:0] ghr1;

    hybrid_bht #(
        .NR_ENTRIES(1024), .INSTR_PER_FETCH(2), .VLEN(39), .RVC(1'b1),
        .CTR_BITS(2), .LOOP_BITS(4), .GHR_BITS(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(debug),
        .vpc_i(vpc), .update_valid_i(upd_valid), .update_pc_i(upd_pc),
        .update_taken_i(upd_taken), .pred_valid_o(pv), .pred_taken_o(pt),
        .pred_src_o(ps), .ghr_o(ghr)
    );

    hybrid_bht #(
        .NR_ENTRIES(1024), .INSTR_PER_FETCH(2), .VLEN(39), .RVC(1'b1),
        .CTR_BITS(2), .LOOP_BITS(4), .GHR_BITS(1)
    ) dut_g1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(debug),
        .vpc_i(vpc), .update_valid_i(upd_valid), .update_pc_i(upd_pc),
        .update_taken_i(upd_taken), .pred_valid_o(pv1), .pred_taken_o(pt1),
        .pred_src_o(ps1), .ghr_o(ghr1)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         sel;   // 0: default instance, 1: GHR_BITS=1 instance
        logic [1:0] v;
        logic [1:0] t;
        logic [1:0] s;
        logic [7:0] g;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        if (e.sel) begin
            chk({e.tag, ".valid"}, {6'b0, pv1}, {6'b0, e.v});
            chk({e.tag, ".taken"}, {6'b0, pt1}, {6'b0, e.t});
            chk({e.tag, ".src"},   {6'b0, ps1}, {6'b0, e.s});
            chk({e.tag, ".ghr"},   {7'b0, ghr1}, e.g);
        end else begin
            chk({e.tag, ".valid"}, {6'b0, pv}, {6'b0, e.v});
            chk({e.tag, ".taken"}, {6'b0, pt}, {6'b0, e.t});
            chk({e.tag, ".src"},   {6'b0, ps}, {6'b0, e.s});
            chk({e.tag, ".ghr"},   ghr, e.g);
        end
    endtask

    // Drive the fetch PC, queue the expectation, compare at the next falling edge.
    task automatic expect_pred(input string tag, input bit sel, input logic [38:0] pc,
                               input logic [1:0] v, input logic [1:0] t,
                               input logic [1:0] s, input logic [7:0] g);
        exp_t e;
        vpc   = pc;
        e.tag = tag;
        e.sel = sel;
        e.v   = v;
        e.t   = t;
        e.s   = s;
        e.g   = g;
        sb_q.push_back(e);
        @(negedge clk);
        sample();
    endtask

    task automatic upd(input logic [38:0] pc, input logic tk);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = tk;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        expect_pred("rst",    1'b0, 39'h80, 2'b00, 2'b11, 2'b00, 8'h00);
        expect_pred("rst_g1", 1'b1, 39'h80, 2'b00, 2'b11, 2'b00, 8'h00);
        #1 rst = 1'b0;

        // Debug mode suppresses updates
        debug = 1'b1;
        repeat (5) upd(39'h80, 1'b1);
        debug = 1'b0;
        expect_pred("debug", 1'b0, 39'h80, 2'b00, 2'b11, 2'b00, 8'h00);

        // Not-taken training at 0x100 (row 0x40) saturates the counter to 0
        repeat (3) upd(39'h100, 1'b0);
        expect_pred("nt3", 1'b0, 39'h100, 2'b01, 2'b10, 2'b00, 8'h00);
        // One taken elsewhere: history 1 moves the counter read to row 0x41 (fresh)
        upd(39'h600, 1'b1);
        expect_pred("ghr_xor", 1'b0, 39'h100, 2'b01, 2'b11, 2'b00, 8'h01);

        // Flush clears everything
        do_flush();
        expect_pred("flush", 1'b0, 39'h100, 2'b00, 2'b11, 2'b00, 8'h00);

        // Four taken updates at 0x200
        repeat (4) upd(39'h200, 1'b1);
        expect_pred("t4", 1'b0, 39'h200, 2'b01, 2'b11, 2'b00, 8'h0F);

        // Loop pattern TTTN x6 at 0x400, observed on the GHR_BITS=1 instance
        do_flush();
        for (int p = 1; p <= 6; p++) begin
            upd(39'h400, 1'b1);
            upd(39'h400, 1'b1);
            if (p == 6) expect_pred("loop_p6_tt", 1'b1, 39'h400, 2'b01, 2'b11, 2'b00, 8'h01);
            upd(39'h400, 1'b1);
            if (p == 2) expect_pred("loop_p2_ttt", 1'b1, 39'h400, 2'b01, 2'b11, 2'b00, 8'h01);
            if (p == 3) expect_pred("loop_p3_ttt", 1'b1, 39'h400, 2'b01, 2'b10, 2'b01, 8'h01);
            if (p == 6) expect_pred("loop_p6_ttt", 1'b1, 39'h400, 2'b01, 2'b10, 2'b01, 8'h01);
            upd(39'h400, 1'b0);
            if (p == 6) expect_pred("loop_p6_n", 1'b1, 39'h400, 2'b01, 2'b11, 2'b00, 8'h00);
        end

        // 20 taken in a row: sequence saturates, counter path selected
        do_flush();
        repeat (20) upd(39'h300, 1'b1);
        expect_pred("t20", 1'b0, 39'h300, 2'b01, 2'b11, 2'b00, 8'hFF);

        // Flush coincident with an update: update dropped
        @(posedge clk);
        #1;
        flush     = 1'b1;
        upd_valid = 1'b1;
        upd_pc    = 39'h100;
        upd_taken = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        upd_valid = 1'b0;
        expect_pred("flush_upd",    1'b0, 39'h100, 2'b00, 2'b11, 2'b00, 8'h00);
        expect_pred("flush_upd_g1", 1'b1, 39'h100, 2'b00, 2'b11, 2'b00, 8'h00);

        // Same-cycle update and prediction on one PC: old value now, new value next cycle
        @(posedge clk);
        #1;
        upd_valid = 1'b1;
        upd_pc    = 39'h100;
        upd_taken = 1'b0;
        expect_pred("rw_old", 1'b0, 39'h100, 2'b00, 2'b11, 2'b00, 8'h00);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        expect_pred("rw_new", 1'b0, 39'h100, 2'b01, 2'b10, 2'b00, 8'h00);

        // Asynchronous reset mid-operation clears state before any clock edge
        upd(39'h100, 1'b1);
        expect_pred("pre_rst", 1'b0, 39'h100, 2'b01, 2'b11, 2'b00, 8'h01);
        @(posedge clk);
        #2 rst = 1'b1;
        expect_pred("async_rst",    1'b0, 39'h100, 2'b00, 2'b11, 2'b00, 8'h00);
        expect_pred("async_rst_g1", 1'b1, 39'h100, 2'b00, 2'b11, 2'b00, 8'h00);
        #1 rst = 1'b0;

        n_assert++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
